// File: rtl/seq_mux_pkg.sv
// Shared constants and helpers for the seq_mux_n registered multiplexer.
// Grant validity is a single bit; NO_GRANT marks "no channel selected this cycle".
package seq_mux_pkg;

    localparam int DEF_N_CH   = 4;
    localparam int DEF_DATA_W = 8;

    localparam logic NO_GRANT = 1'b0;
    localparam logic GRANT    = 1'b1;

    // Ceiling log2, usable in parameter defaults.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Modular add for indices already below n.
    function automatic int mod_add(input int a, input int b, input int n);
        int s;
        s = a + b;
        return (s >= n) ? (s - n) : s;
    endfunction

endpackage

// File: rtl/seq_mux_n_rr_arbiter.sv
// Channel arbiter for seq_mux_n: round-robin when SEQ_MUX_RR_EN is defined,
// otherwise fixed priority (lowest valid index wins, rr_ptr ignored).
module rr_arbiter
    import seq_mux_pkg::*;
#(
    parameter int N_CH  = DEF_N_CH,
    parameter int SEL_W = clog2(N_CH)
) (
    input  logic [N_CH-1:0]  in_valid,
    input  logic [SEL_W-1:0] rr_ptr,
    input  logic             en,
    output logic [SEL_W-1:0] grant,
    output logic             grant_valid
);

`ifdef SEQ_MUX_RR_EN
    // First valid channel at or after rr_ptr, wrapping modulo N_CH.
    always_comb begin : rr_search
        logic [SEL_W-1:0] v_idx;
        v_idx       = '0;
        grant       = '0;
        grant_valid = NO_GRANT;
        for (int k = 0; k < N_CH; k++) begin
            v_idx = SEL_W'(mod_add(int'(rr_ptr), k, N_CH));
            if (en && (grant_valid == NO_GRANT) && in_valid[v_idx]) begin
                grant       = v_idx;
                grant_valid = GRANT;
            end
        end
    end
`else
    logic w_unused_ptr;
    assign w_unused_ptr = ^rr_ptr;

    // Descending scan so the lowest valid index is the final assignment.
    always_comb begin
        grant       = '0;
        grant_valid = NO_GRANT;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (en && in_valid[k]) begin
                grant       = SEL_W'(k);
                grant_valid = GRANT;
            end
        end
    end
`endif

endmodule

// File: rtl/seq_mux_n.sv
// Registered N-channel valid/ready multiplexer with forced-select override.
// Build option: define SEQ_MUX_RR_EN for round-robin arbitration (default fixed priority).
module seq_mux_n
    import seq_mux_pkg::*;
#(
    parameter  int N_CH   = DEF_N_CH,
    parameter  int DATA_W = DEF_DATA_W,
    localparam int SEL_W  = clog2(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CH*DATA_W-1:0] in_data,
    input  logic [N_CH-1:0]        in_valid,
    output logic [N_CH-1:0]        in_ready,
    input  logic                   force_en,
    input  logic [SEL_W-1:0]       force_sel,
    output logic [DATA_W-1:0]      out_data,
    output logic [SEL_W-1:0]       out_sel,
    output logic                   out_valid,
    input  logic                   out_ready
);

    logic [SEL_W-1:0]  w_arb_grant;
    logic              w_arb_gv;
    logic              w_force_gv;
    logic [SEL_W-1:0]  w_grant;
    logic              w_grant_valid;
    logic [SEL_W-1:0]  w_rr_ptr;
    logic              w_free;
    logic              w_xfer;
    logic [DATA_W-1:0] w_word;

    logic [DATA_W-1:0] r_data_p1;
    logic [SEL_W-1:0]  r_sel_p1;
    logic              r_vld_p1;

    rr_arbiter #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_arb (
        .in_valid    (in_valid),
        .rr_ptr      (w_rr_ptr),
        .en          (!force_en),
        .grant       (w_arb_grant),
        .grant_valid (w_arb_gv)
    );

    // Compare against each legal index so an out-of-range force_sel yields no grant, never X.
    always_comb begin
        w_force_gv = NO_GRANT;
        for (int i = 0; i < N_CH; i++) begin
            if ((force_sel == SEL_W'(i)) && in_valid[i]) begin
                w_force_gv = GRANT;
            end
        end
    end

    assign w_grant       = force_en ? force_sel  : w_arb_grant;
    assign w_grant_valid = force_en ? w_force_gv : w_arb_gv;
    assign w_free        = !r_vld_p1 || out_ready;
    assign w_xfer        = !rst && w_free && w_grant_valid;

    always_comb begin
        in_ready = '0;
        w_word   = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_grant == SEL_W'(i)) begin
                in_ready[i] = w_xfer;
                w_word      = in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Stage p0 -> p1: output register; load has priority over drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p1  <= 1'b0;
            r_data_p1 <= '0;
            r_sel_p1  <= '0;
        end else if (w_xfer) begin
            r_vld_p1  <= 1'b1;
            r_data_p1 <= w_word;
            r_sel_p1  <= w_grant;
        end else if (out_ready) begin
            r_vld_p1  <= 1'b0;
        end
    end

`ifdef SEQ_MUX_RR_EN
    logic [SEL_W-1:0] r_rr_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_xfer && !force_en) begin
            r_rr_ptr <= (w_grant == SEL_W'(N_CH - 1)) ? '0 : w_grant + 1'b1;
        end
    end

    assign w_rr_ptr = r_rr_ptr;
`else
    assign w_rr_ptr = '0;
`endif

    assign out_data  = r_data_p1;
    assign out_sel   = r_sel_p1;
    assign out_valid = r_vld_p1;

endmodule

// File: tb/tb_seq_mux_n.sv
// Directed bench for seq_mux_n (4-channel) plus a 3-channel instance for out-of-range force_sel.
module tb_seq_mux_n;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic        force_en;
    logic [1:0]  force_sel;
    logic [7:0]  out_data;
    logic [1:0]  out_sel;
    logic        out_valid;
    logic        out_ready;

    logic [23:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic        force_en3;
    logic [1:0]  force_sel3;
    logic [7:0]  out_data3;
    logic [1:0]  out_sel3;
    logic        out_valid3;
    logic        out_ready3;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [9:0]  sb[$];
    bit          m_vld;
    int          m_ptr;

    always #5 clk = ~clk;

    seq_mux_n #(.N_CH(4), .DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .force_en  (force_en),
        .force_sel (force_sel),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    seq_mux_n #(.N_CH(3), .DATA_W(8)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .force_en  (force_en3),
        .force_sel (force_sel3),
        .out_data  (out_data3),
        .out_sel   (out_sel3),
        .out_valid (out_valid3),
        .out_ready (out_ready3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference grant for the 4-channel instance; -1 means no grant.
    function automatic int model_grant(input logic [3:0] v, input logic fe, input logic [1:0] fs, input int ptr);
        if (fe) begin
            return v[fs] ? int'(fs) : -1;
        end
`ifdef SEQ_MUX_RR_EN
        for (int k = 0; k < 4; k++) begin
            if (v[(ptr + k) % 4]) return (ptr + k) % 4;
        end
`else
        for (int k = 0; k < 4; k++) begin
            if (v[k]) return k;
        end
`endif
        return -1;
    endfunction

    // One clock of stimulus: drive at negedge, check handshake and scoreboard, update the model.
    task automatic drive(input string tag, input logic [3:0] v, input logic [31:0] d,
                         input logic fe, input logic [1:0] fs, input logic ordy);
        int         g;
        bit         free;
        logic [3:0] er;
        logic [9:0] e;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        force_en  = fe;
        force_sel = fs;
        out_ready = ordy;
        #1;
        g    = model_grant(v, fe, fs, m_ptr);
        free = !m_vld || ordy;
        er   = (free && g >= 0) ? 4'(1 << g) : 4'b0000;
        check({tag, ".in_ready"}, in_ready, er);
        check({tag, ".out_valid"}, out_valid, m_vld);
        if (m_vld && ordy) begin
            n_cmp++;
            assert (sb.size() > 0) else begin
                n_err++;
                $error("FAIL %s.sb_underflow: observed=empty expected=entry", tag);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({tag, ".out_data"}, out_data, e[7:0]);
                check({tag, ".out_sel"}, out_sel, e[9:8]);
            end
        end
        if (free && g >= 0) begin
            sb.push_back({2'(g), d[g*8 +: 8]});
`ifdef SEQ_MUX_RR_EN
            if (!fe) m_ptr = (g == 3) ? 0 : g + 1;
`endif
        end
        m_vld = (free && g >= 0) ? 1'b1 : (ordy ? 1'b0 : m_vld);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge.
    task automatic reset_pulse(input string tag);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check({tag, ".out_valid"}, out_valid, 0);
        check({tag, ".out_data"}, out_data, 0);
        check({tag, ".out_sel"}, out_sel, 0);
        check({tag, ".in_ready"}, in_ready, 0);
        @(negedge clk);
        rst       = 1'b0;
        in_valid  = '0;
        force_en  = 1'b0;
        in_valid3 = '0;
        force_en3 = 1'b0;
        m_vld     = 1'b0;
        m_ptr     = 0;
        sb.delete();
    endtask

    initial begin
        int exp_seq[5];
        rst        = 1'b0;
        in_data    = '0;
        in_valid   = '0;
        force_en   = 1'b0;
        force_sel  = '0;
        out_ready  = 1'b0;
        in_data3   = '0;
        in_valid3  = '0;
        force_en3  = 1'b0;
        force_sel3 = '0;
        out_ready3 = 1'b0;
        m_vld      = 1'b0;
        m_ptr      = 0;

        #1 rst = 1'b1;
        #2;
        check("init.out_valid", out_valid, 0);
        check("init.out_data", out_data, 0);
        check("init.out_sel", out_sel, 0);
        check("init.in_ready", in_ready, 0);
        check("init3.out_valid", out_valid3, 0);
        @(negedge clk);
        rst = 1'b0;

        drive("force", 4'b1111, 32'h443C2211, 1'b1, 2'd2, 1'b1);
        check("force.rdy_direct", in_ready, 4'b0100);
        drive("force_idle", 4'b0000, 32'h0, 1'b1, 2'd2, 1'b1);
        check("force.data_direct", out_data, 8'h3C);
        check("force.sel_direct", out_sel, 2);
        drive("force_novalid", 4'b1101, 32'h44332211, 1'b1, 2'd1, 1'b1);
        check("force_novalid.rdy_direct", in_ready, 4'b0000);
        drive("force_off", 4'b1101, 32'h44332211, 1'b0, 2'd1, 1'b1);
        drive("idle0", 4'b0000, 32'h0, 1'b0, 2'd0, 1'b1);

        @(negedge clk);
        force_en3  = 1'b1;
        force_sel3 = 2'd3;
        in_valid3  = 3'b111;
        in_data3   = 24'h332211;
        out_ready3 = 1'b1;
        #1 check("inv3.in_ready", in_ready3, 0);
        @(negedge clk);
        #1 check("inv3.out_valid", out_valid3, 0);
        force_sel3 = 2'd2;
        #1 check("sel3.in_ready", in_ready3, 3'b100);
        @(negedge clk);
        in_valid3 = '0;
        force_en3 = 1'b0;
        #1;
        check("sel3.out_data", out_data3, 8'h33);
        check("sel3.out_sel", out_sel3, 2);

        drive("pre_rst", 4'b0001, 32'h000000A5, 1'b0, 2'd0, 1'b0);
        drive("pre_rst_hold", 4'b0001, 32'h000000A5, 1'b0, 2'd0, 1'b0);
        check("pre_rst.data_direct", out_data, 8'hA5);
        reset_pulse("rst_mid");

        drive("bp_load", 4'b0011, 32'h0000B2A1, 1'b0, 2'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive("bp_stall", 4'b0011, 32'h0000B2A1, 1'b0, 2'd0, 1'b0);
            check("bp_stall.rdy_direct", in_ready, 4'b0000);
            check("bp_stall.data_hold", out_data, 8'hA1);
        end
        drive("bp_release", 4'b0011, 32'h0000B2A1, 1'b0, 2'd0, 1'b1);
        drive("bp_after", 4'b0000, 32'h0, 1'b0, 2'd0, 1'b1);
`ifdef SEQ_MUX_RR_EN
        check("bp_after.data_direct", out_data, 8'hB2);
`else
        check("bp_after.data_direct", out_data, 8'hA1);
`endif
        reset_pulse("rst2");

`ifdef SEQ_MUX_RR_EN
        exp_seq = '{0, 1, 2, 3, 0};
`else
        exp_seq = '{0, 0, 0, 0, 0};
`endif
        for (int i = 0; i < 6; i++) begin
            drive("rr_seq", (i < 5) ? 4'b1111 : 4'b0000, 32'h44332211, 1'b0, 2'd0, 1'b1);
            if (i > 0) check("rr_seq.out_sel_direct", out_sel, exp_seq[i-1]);
        end

        drive("wrap_a", 4'b0100, 32'h44332211, 1'b0, 2'd0, 1'b1);
        drive("wrap_b", 4'b0010, 32'h44332211, 1'b0, 2'd0, 1'b1);
        check("wrap_b.rdy_direct", in_ready, 4'b0010);
        drive("wrap_c", 4'b1011, 32'h44332211, 1'b0, 2'd0, 1'b1);
`ifdef SEQ_MUX_RR_EN
        check("wrap_c.rdy_direct", in_ready, 4'b1000);
`else
        check("wrap_c.rdy_direct", in_ready, 4'b0001);
`endif
        drive("idle1", 4'b0000, 32'h0, 1'b0, 2'd0, 1'b1);
        drive("idle2", 4'b0000, 32'h0, 1'b0, 2'd0, 1'b1);
        check("sb.final_size", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
